// File: rtl/imem_fetch.sv
// Instruction-fetch front end: drives the synchronous instruction RAM, tracks the
// single in-flight read and presents buffered {pc, instruction} pairs to decode.

package imem_fetch_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_entry_t;
endpackage

module imem_fetch
  import imem_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_din,
  input  logic [XLEN-1:0] mem_dout,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_data,
  input  logic            inst_ready
);

  localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_BASE = RESET_PC & PC_MASK;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  fetch_entry_t    head_q, head_d;
  fetch_entry_t    tail_q, tail_d;
  logic [1:0]      vld_q, vld_d;

  logic            pop_c;
  logic            issue_c;
  logic [2:0]      occ_c;
  fetch_entry_t    ret_c;

  // Occupancy after this cycle's pop decides whether one more read may launch,
  // so a returning word always has a free slot.
  always_comb begin
    pop_c   = vld_q[0] & inst_ready;
    occ_c   = 3'(vld_q[0]) + 3'(vld_q[1]) + 3'(req_q) - 3'(pop_c);
    issue_c = ~redirect_valid & (occ_c < 3'd2);
    ret_c   = '{pc: req_pc_q, data: mem_dout};
  end

  // Next state: flush on redirect, otherwise pop-shift then append the returning word.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    req_pc_d   = req_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    vld_d      = vld_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & PC_MASK;
      req_d      = 1'b0;
      vld_d      = 2'b00;
    end else begin
      if (pop_c) begin
        head_d = tail_q;
        vld_d  = {1'b0, vld_q[1]};
      end
      if (req_q) begin
        if (!vld_d[0]) begin
          head_d   = ret_c;
          vld_d[0] = 1'b1;
        end else begin
          tail_d   = ret_c;
          vld_d[1] = 1'b1;
        end
      end
      req_d = issue_c;
      if (issue_c) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= PC_BASE;
      req_q      <= 1'b0;
      req_pc_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      vld_q      <= 2'b00;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      req_pc_q   <= req_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      vld_q      <= vld_d;
    end
  end

  // Outputs come straight from state registers; the write port is tied off.
  assign mem_addr   = fetch_pc_q;
  assign mem_we     = 1'b0;
  assign mem_din    = '0;
  assign inst_valid = vld_q[0];
  assign inst_pc    = head_q.pc;
  assign inst_data  = head_q.data;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: a queue-based fetch model plus a RAM model, checked every
// cycle, with directed scenarios followed by randomized ready/redirect traffic.

module tb_imem_fetch;
  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;

  int errors = 0;
  int checks = 0;

  // Model state: buffered pcs in order, the outstanding read and the next fetch address.
  logic [31:0] m_q[$];
  bit          m_inf;
  logic [31:0] m_inf_pc;
  logic [31:0] m_fpc;
  logic [31:0] acc_log[$];

  imem_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'h0262_81b3;
      32'h4:   return 32'h0262_c233;
      32'h8:   return 32'h0262_e3b3;
      default: return (addr * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endcase
  endfunction

  // Registered-read instruction RAM.
  always @(posedge clk) mem_dout <= ram_word(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_inf    = 1'b0;
    m_inf_pc = 32'h0;
    m_fpc    = 32'h0;
  endtask

  task automatic model_edge();
    bit pop;
    int occ;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pop = (m_q.size() != 0) && inst_ready;
    if (redirect_valid) begin
      m_q.delete();
      m_inf = 1'b0;
      m_fpc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      occ = m_q.size() + int'(m_inf) - int'(pop);
      if (pop) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_inf_pc);
      if (occ < 2) begin
        m_inf    = 1'b1;
        m_inf_pc = m_fpc;
        m_fpc    = m_fpc + 32'd4;
      end else begin
        m_inf = 1'b0;
      end
    end
  endtask

  task automatic compare();
    chk("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("inst_pc", inst_pc, m_q[0]);
      chk("inst_data", inst_data, ram_word(m_q[0]));
    end
    if (!rst_n) begin
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_inst_data", inst_data, 32'h0);
    end
    chk("mem_addr", mem_addr, m_fpc);
    chk("mem_we", 32'(mem_we), 32'h0);
    chk("mem_din", mem_din, 32'h0);
  endtask

  // One clock: log an accepted handshake, advance the model at the edge, compare after it.
  task automatic step();
    if (rst_n && inst_valid && inst_ready) acc_log.push_back(inst_pc);
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Reset asserted between edges must clear the outputs at once; released one cycle later.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(inst_valid), 32'h0);
    chk("async_mem_addr", mem_addr, 32'h0);
    chk("async_inst_pc", inst_pc, 32'h0);
    chk("async_mem_we", 32'(mem_we), 32'h0);
    model_reset();
    redirect_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    #1;
    compare();
    step();
    step();
    rst_n = 1'b1;

    // Reset release: first instruction two cycles later, then back to back.
    inst_ready = 1'b1;
    step();
    chk("t1_c1_valid", 32'(inst_valid), 32'h0);
    step();
    chk("t1_pc0", inst_pc, 32'h0);
    chk("t1_mul", inst_data, 32'h0262_81b3);
    step();
    chk("t1_pc4", inst_pc, 32'h4);
    chk("t1_div", inst_data, 32'h0262_c233);
    step();
    chk("t1_pc8", inst_pc, 32'h8);
    chk("t1_rem", inst_data, 32'h0262_e3b3);

    // Backpressure from first valid: buffer fills, fetch stalls at 0x8, head holds.
    async_reset();
    inst_ready = 1'b1;
    step();
    step();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t2_head_pc", inst_pc, 32'h0);
    chk("t2_valid", 32'(inst_valid), 32'h1);
    chk("t2_mem_addr", mem_addr, 32'h8);
    acc_log.delete();
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t2_acc_n", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      chk("t2_acc_pc", acc_log[i], 32'(4 * i));

    // Redirect with a full buffer: flushed next cycle, new pc valid three cycles later.
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("t3_flush_valid", 32'(inst_valid), 32'h0);
    chk("t3_mem_addr", mem_addr, 32'h40);
    step();
    chk("t3_t2_valid", 32'(inst_valid), 32'h0);
    step();
    chk("t3_t3_valid", 32'(inst_valid), 32'h1);
    chk("t3_t3_pc", inst_pc, 32'h40);

    // Misaligned redirect and wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h13;
    step();
    redirect_valid = 1'b0;
    chk("t4_align", mem_addr, 32'h10);
    inst_ready = 1'b1;
    step();
    step();
    chk("t4_pc10", inst_pc, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("t4_top_addr", mem_addr, 32'hFFFF_FFFC);
    step();
    chk("t4_wrap_addr", mem_addr, 32'h0);
    step();
    chk("t4_top_pc", inst_pc, 32'hFFFF_FFFC);
    step();
    chk("t4_wrap_pc", inst_pc, 32'h0);

    // Redirect coinciding with a pop: that word is accepted once, the rest flushed.
    step();
    acc_log.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("t5_flush_valid", 32'(inst_valid), 32'h0);
    step();
    step();
    chk("t5_new_pc", inst_pc, 32'h200);
    step();
    chk("t5_acc_n", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2) begin
      chk("t5_acc0", acc_log[0], 32'h4);
      chk("t5_acc1", acc_log[1], 32'h200);
    end

    // Random ready/redirect traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) begin
        async_reset();
      end else begin
        inst_ready     = ($urandom_range(0, 99) < 70);
        redirect_valid = ($urandom_range(0, 19) == 0);
        redirect_pc    = $urandom;
        if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        step();
      end
    end
    redirect_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
